// File: rtl/seg7_reader_if.sv
// Segment-bus and report handshake bundle for seg7_reader.
interface seg7_reader_if;
    logic [6:0] seg_tens;
    logic [6:0] seg_units;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_tens;
    logic [3:0] out_units;
    logic [6:0] out_value;
    logic       out_err;

    modport master (
        output seg_tens, seg_units, out_ready,
        input  out_valid, out_tens, out_units, out_value, out_err
    );

    modport slave (
        input  seg_tens, seg_units, out_ready,
        output out_valid, out_tens, out_units, out_value, out_err
    );
endinterface

// File: rtl/seg7_reader.sv
// Debounces a pair of active-low 7-segment buses and offers each newly
// settled two-digit reading once over a valid/ready handshake.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg7_reader_if.slave bus
);
    typedef enum logic {TRACK, OFFER} state_t;

    localparam logic [7:0] SAT = 8'(STABLE_CYCLES);

    state_t      state_q;
    logic [13:0] smp_q, smp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        acc_vld_q;
    logic [13:0] acc_pair_q;
    logic [13:0] off_pair_q;
    logic        out_valid_q;
    logic [3:0]  out_tens_q, out_units_q;
    logic [6:0]  out_value_q;
    logic        out_err_q;

    logic [4:0]  tens_dec, units_dec;
    logic [6:0]  value;
    logic        settled, new_pair;

    // Result is {invalid, digit}; invalid patterns yield digit 0.
    function automatic logic [4:0] dec(input logic [6:0] p, input logic blank_ok);
        case (p)
            7'h40:   dec = 5'd0;
            7'h79:   dec = 5'd1;
            7'h24:   dec = 5'd2;
            7'h30:   dec = 5'd3;
            7'h19:   dec = 5'd4;
            7'h12:   dec = 5'd5;
            7'h02:   dec = 5'd6;
            7'h78:   dec = 5'd7;
            7'h00:   dec = 5'd8;
            7'h10:   dec = 5'd9;
            7'h7F:   dec = blank_ok ? 5'd0 : 5'h10;
            default: dec = 5'h10;
        endcase
    endfunction

    always_comb begin
        smp_d = {bus.seg_tens, bus.seg_units};
        if (smp_d == smp_q)
            cnt_d = (cnt_q == SAT) ? SAT : cnt_q + 8'd1;
        else
            cnt_d = 8'd0;
        // Already saturated covers a pair that settled while an offer was pending.
        settled   = (cnt_q == SAT) || (cnt_d == SAT);
        new_pair  = !acc_vld_q || (smp_q != acc_pair_q);
        tens_dec  = dec(smp_q[13:7], 1'b1);
        units_dec = dec(smp_q[6:0], 1'b0);
        value     = {tens_dec[3:0], 3'b000} + {2'b00, tens_dec[3:0], 1'b0}
                  + {3'b000, units_dec[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TRACK;
            smp_q       <= '1;
            cnt_q       <= '0;
            acc_vld_q   <= 1'b0;
            acc_pair_q  <= '0;
            off_pair_q  <= '0;
            out_valid_q <= 1'b0;
            out_tens_q  <= '0;
            out_units_q <= '0;
            out_value_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            smp_q <= smp_d;
            cnt_q <= cnt_d;
            case (state_q)
                TRACK: begin
                    if (settled && new_pair) begin
                        state_q     <= OFFER;
                        out_valid_q <= 1'b1;
                        off_pair_q  <= smp_q;
                        out_tens_q  <= tens_dec[3:0];
                        out_units_q <= units_dec[3:0];
                        out_value_q <= value;
                        out_err_q   <= tens_dec[4] | units_dec[4];
                    end
                end
                OFFER: begin
                    if (bus.out_ready) begin
                        state_q     <= TRACK;
                        out_valid_q <= 1'b0;
                        acc_vld_q   <= 1'b1;
                        acc_pair_q  <= off_pair_q;
                    end
                end
                default: state_q <= TRACK;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_tens  = out_tens_q;
    assign bus.out_units = out_units_q;
    assign bus.out_value = out_value_q;
    assign bus.out_err   = out_err_q;
endmodule
